// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the 32-bit ALU. It decodes a MIPS instruction into an ALU code,
// operands and a branch type, and registers them with stall, flush and illegal reporting.
module alu_issue_stage (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        InValid,
   input  logic [31:0] Instr,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   input  logic        Stall,
   input  logic        Flush,
   output logic        OutValid,
   output logic [5:0]  ALUControl,
   output logic [31:0] ALUA,
   output logic [31:0] ALUB,
   output logic [2:0]  BranchType,
   output logic        Illegal,
   output logic [7:0]  IllegalCount
);

   localparam logic [5:0] ALU_ADD = 6'b100000;
   localparam logic [5:0] ALU_SUB = 6'b100010;
   localparam logic [5:0] ALU_MUL = 6'b011000;
   localparam logic [5:0] ALU_AND = 6'b100100;
   localparam logic [5:0] ALU_OR  = 6'b100101;
   localparam logic [5:0] ALU_NOR = 6'b100111;
   localparam logic [5:0] ALU_XOR = 6'b100110;
   localparam logic [5:0] ALU_SLL = 6'b000000;
   localparam logic [5:0] ALU_SRL = 6'b000010;
   localparam logic [5:0] ALU_SLT = 6'b101010;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BGEZ = 3'b011;
   localparam logic [2:0] BR_BGTZ = 3'b100;
   localparam logic [2:0] BR_BLEZ = 3'b101;
   localparam logic [2:0] BR_BLTZ = 3'b110;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_field;
   logic [31:0] sext_imm;
   logic [31:0] zext_imm;
   logic [31:0] shamt_ext;

   logic        dec_ok;
   logic [5:0]  dec_ctrl;
   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [2:0]  dec_br;

   assign opcode    = Instr[31:26];
   assign funct     = Instr[5:0];
   assign rt_field  = Instr[20:16];
   assign sext_imm  = {{16{Instr[15]}}, Instr[15:0]};
   assign zext_imm  = {16'b0, Instr[15:0]};
   assign shamt_ext = {27'b0, Instr[10:6]};

   // Defaults describe the load/store address form (rs + sext), which most opcodes share.
   always_comb begin
      dec_ok   = 1'b1;
      dec_ctrl = ALU_ADD;
      dec_a    = RsData;
      dec_b    = sext_imm;
      dec_br   = BR_NONE;
      case (opcode)
         6'b000000: begin
            dec_b = RtData;
            case (funct)
               6'b100000: dec_ctrl = ALU_ADD;
               6'b100010: dec_ctrl = ALU_SUB;
               6'b100100: dec_ctrl = ALU_AND;
               6'b100101: dec_ctrl = ALU_OR;
               6'b100111: dec_ctrl = ALU_NOR;
               6'b100110: dec_ctrl = ALU_XOR;
               6'b101010: dec_ctrl = ALU_SLT;
               6'b000000: begin
                  dec_ctrl = ALU_SLL;
                  dec_a    = RtData;
                  dec_b    = shamt_ext;
               end
               6'b000010: begin
                  dec_ctrl = ALU_SRL;
                  dec_a    = RtData;
                  dec_b    = shamt_ext;
               end
               default: dec_ok = 1'b0;
            endcase
         end
         6'b011100: begin
            dec_ctrl = ALU_MUL;
            dec_b    = RtData;
            if (funct != 6'b000010) dec_ok = 1'b0;
         end
         6'b001000: dec_ctrl = ALU_ADD;
         6'b001010: dec_ctrl = ALU_SLT;
         6'b001100: begin
            dec_ctrl = ALU_AND;
            dec_b    = zext_imm;
         end
         6'b001101: begin
            dec_ctrl = ALU_OR;
            dec_b    = zext_imm;
         end
         6'b001110: begin
            dec_ctrl = ALU_XOR;
            dec_b    = zext_imm;
         end
         6'b100011, 6'b101011, 6'b100000,
         6'b100001, 6'b101000, 6'b101001: dec_ctrl = ALU_ADD;
         6'b000100: begin
            dec_ctrl = ALU_SUB;
            dec_b    = RtData;
            dec_br   = BR_BEQ;
         end
         6'b000101: begin
            dec_ctrl = ALU_SUB;
            dec_b    = RtData;
            dec_br   = BR_BNE;
         end
         6'b000001: begin
            dec_ctrl = ALU_SUB;
            dec_b    = 32'b0;
            case (rt_field)
               5'b00001: dec_br = BR_BGEZ;
               5'b00000: dec_br = BR_BLTZ;
               default:  dec_ok = 1'b0;
            endcase
         end
         6'b000110: begin
            dec_ctrl = ALU_SUB;
            dec_b    = 32'b0;
            dec_br   = BR_BLEZ;
         end
         6'b000111: begin
            dec_ctrl = ALU_SUB;
            dec_b    = 32'b0;
            dec_br   = BR_BGTZ;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // Flush beats Stall beats an empty slot; an illegal capture issues a bubble and pulses Illegal.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         OutValid     <= 1'b0;
         ALUControl   <= ALU_ADD;
         ALUA         <= 32'b0;
         ALUB         <= 32'b0;
         BranchType   <= BR_NONE;
         Illegal      <= 1'b0;
         IllegalCount <= 8'd0;
      end else if (Stall && !Flush) begin
         Illegal <= 1'b0;
      end else if (Flush || !InValid || !dec_ok) begin
         OutValid   <= 1'b0;
         ALUControl <= ALU_ADD;
         ALUA       <= 32'b0;
         ALUB       <= 32'b0;
         BranchType <= BR_NONE;
         Illegal    <= 1'b0;
         if (!Flush && InValid && !dec_ok) begin
            Illegal <= 1'b1;
            if (IllegalCount != 8'hFF) IllegalCount <= IllegalCount + 8'd1;
         end
      end else begin
         OutValid   <= 1'b1;
         ALUControl <= dec_ctrl;
         ALUA       <= dec_a;
         ALUB       <= dec_b;
         BranchType <= dec_br;
         Illegal    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus random traffic, checked against
// a mnemonic-level reference model of the issue stage.
module tb_alu_issue_stage;

   logic        Clk;
   logic        Rst_n;
   logic        InValid;
   logic [31:0] Instr;
   logic [31:0] RsData;
   logic [31:0] RtData;
   logic        Stall;
   logic        Flush;
   logic        OutValid;
   logic [5:0]  ALUControl;
   logic [31:0] ALUA;
   logic [31:0] ALUB;
   logic [2:0]  BranchType;
   logic        Illegal;
   logic [7:0]  IllegalCount;

   int n_asserts = 0;
   int n_fail    = 0;
   int step_no   = 0;

   typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_XOR, M_SLT, M_SLL, M_SRL, M_MUL,
                 M_ADDI, M_SLTI, M_ANDI, M_ORI, M_XORI, M_MEM, M_BEQ, M_BNE,
                 M_BGEZ, M_BLTZ, M_BLEZ, M_BGTZ} mnem_t;

   // Expected registered state of the stage
   logic        e_valid;
   logic [5:0]  e_ctrl;
   logic [31:0] e_a;
   logic [31:0] e_b;
   logic [2:0]  e_br;
   logic        e_ill;
   int          e_cnt;

   alu_issue_stage dut (
      .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Instr(Instr),
      .RsData(RsData), .RtData(RtData), .Stall(Stall), .Flush(Flush),
      .OutValid(OutValid), .ALUControl(ALUControl), .ALUA(ALUA), .ALUB(ALUB),
      .BranchType(BranchType), .Illegal(Illegal), .IllegalCount(IllegalCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic mnem_t classify(input logic [31:0] i);
      logic [5:0] op;
      logic [5:0] fn;
      op = i[31:26];
      fn = i[5:0];
      case (op)
         6'd0: case (fn)
            6'd32: return M_ADD;
            6'd34: return M_SUB;
            6'd36: return M_AND;
            6'd37: return M_OR;
            6'd39: return M_NOR;
            6'd38: return M_XOR;
            6'd42: return M_SLT;
            6'd0:  return M_SLL;
            6'd2:  return M_SRL;
            default: return M_ILL;
         endcase
         6'd28: return (fn == 6'd2) ? M_MUL : M_ILL;
         6'd8:  return M_ADDI;
         6'd10: return M_SLTI;
         6'd12: return M_ANDI;
         6'd13: return M_ORI;
         6'd14: return M_XORI;
         6'd35, 6'd43, 6'd32, 6'd33, 6'd40, 6'd41: return M_MEM;
         6'd4:  return M_BEQ;
         6'd5:  return M_BNE;
         6'd1:  return (i[20:16] == 5'd1) ? M_BGEZ : ((i[20:16] == 5'd0) ? M_BLTZ : M_ILL);
         6'd6:  return M_BLEZ;
         6'd7:  return M_BGTZ;
         default: return M_ILL;
      endcase
   endfunction

   task automatic load_bubble();
      e_valid = 1'b0;
      e_ctrl  = 6'b100000;
      e_a     = 32'd0;
      e_b     = 32'd0;
      e_br    = 3'd0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      mnem_t m;
      logic [31:0] imm_s;
      logic [31:0] imm_z;
      if (Flush) begin
         load_bubble();
         e_ill = 1'b0;
      end else if (Stall) begin
         e_ill = 1'b0;
      end else if (!InValid) begin
         load_bubble();
         e_ill = 1'b0;
      end else begin
         m = classify(Instr);
         imm_s = 32'(signed'(Instr[15:0]));
         imm_z = 32'(Instr[15:0]);
         e_ill = 1'b0;
         e_valid = 1'b1;
         e_a = RsData;
         e_br = 3'd0;
         case (m)
            M_ADD: begin e_ctrl = 6'b100000; e_b = RtData; end
            M_SUB: begin e_ctrl = 6'b100010; e_b = RtData; end
            M_AND: begin e_ctrl = 6'b100100; e_b = RtData; end
            M_OR:  begin e_ctrl = 6'b100101; e_b = RtData; end
            M_NOR: begin e_ctrl = 6'b100111; e_b = RtData; end
            M_XOR: begin e_ctrl = 6'b100110; e_b = RtData; end
            M_SLT: begin e_ctrl = 6'b101010; e_b = RtData; end
            M_MUL: begin e_ctrl = 6'b011000; e_b = RtData; end
            M_SLL: begin e_ctrl = 6'b000000; e_a = RtData; e_b = 32'(Instr[10:6]); end
            M_SRL: begin e_ctrl = 6'b000010; e_a = RtData; e_b = 32'(Instr[10:6]); end
            M_ADDI, M_MEM: begin e_ctrl = 6'b100000; e_b = imm_s; end
            M_SLTI: begin e_ctrl = 6'b101010; e_b = imm_s; end
            M_ANDI: begin e_ctrl = 6'b100100; e_b = imm_z; end
            M_ORI:  begin e_ctrl = 6'b100101; e_b = imm_z; end
            M_XORI: begin e_ctrl = 6'b100110; e_b = imm_z; end
            M_BEQ:  begin e_ctrl = 6'b100010; e_b = RtData; e_br = 3'd1; end
            M_BNE:  begin e_ctrl = 6'b100010; e_b = RtData; e_br = 3'd2; end
            M_BGEZ: begin e_ctrl = 6'b100010; e_b = 32'd0; e_br = 3'd3; end
            M_BGTZ: begin e_ctrl = 6'b100010; e_b = 32'd0; e_br = 3'd4; end
            M_BLEZ: begin e_ctrl = 6'b100010; e_b = 32'd0; e_br = 3'd5; end
            M_BLTZ: begin e_ctrl = 6'b100010; e_b = 32'd0; e_br = 3'd6; end
            default: begin
               load_bubble();
               e_ill = 1'b1;
               if (e_cnt < 255) e_cnt = e_cnt + 1;
            end
         endcase
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s step %0d: observed %h expected %h", tag, step_no, got, exp);
      end
   endtask

   task automatic check_output();
      chk("OutValid", 32'(OutValid), 32'(e_valid));
      chk("ALUControl", 32'(ALUControl), 32'(e_ctrl));
      chk("ALUA", ALUA, e_a);
      chk("ALUB", ALUB, e_b);
      chk("BranchType", 32'(BranchType), 32'(e_br));
      chk("Illegal", 32'(Illegal), 32'(e_ill));
      chk("IllegalCount", 32'(IllegalCount), 32'(e_cnt));
   endtask

   task automatic apply_stimulus(input logic v, input logic [31:0] i, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic st, input logic fl);
      InValid = v;
      Instr   = i;
      RsData  = rs;
      RtData  = rt;
      Stall   = st;
      Flush   = fl;
   endtask

   task automatic step();
      model_edge();
      @(posedge Clk);
      #1;
      step_no++;
      check_output();
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [19];
      logic [5:0] fns [11];
      logic [31:0] w;
      ops = '{6'd0, 6'd0, 6'd0, 6'd28, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43,
              6'd32, 6'd41, 6'd4, 6'd5, 6'd1, 6'd6, 6'd7, 6'd63};
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd38, 6'd42, 6'd0, 6'd2, 6'd24, 6'd13};
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 18)];
      if ((w[31:26] == 6'd0 || w[31:26] == 6'd28) && $urandom_range(0, 4) != 0)
         w[5:0] = fns[$urandom_range(0, 10)];
      if (w[31:26] == 6'd1 && $urandom_range(0, 3) != 0)
         w[20:16] = 5'($urandom_range(0, 1));
      return w;
   endfunction

   initial begin
      apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      Rst_n = 1'b0;
      load_bubble();
      e_ill = 1'b0;
      e_cnt = 0;
      #12;
      check_output();
      #3 Rst_n = 1'b1;
      @(posedge Clk);
      #1;

      // addi: sign-extended immediate
      apply_stimulus(1'b1, enc_i(6'd8, 5'd5, 5'd2, 16'hFFFF), 32'h10, 32'h99, 1'b0, 1'b0);
      step();
      chk("addi_B", ALUB, 32'hFFFFFFFF);
      chk("addi_A", ALUA, 32'h10);

      // ori zero-extends, then sll takes rt and shamt
      apply_stimulus(1'b1, enc_i(6'd13, 5'd1, 5'd2, 16'h8001), 32'h5, 32'h6, 1'b0, 1'b0);
      step();
      chk("ori_B", ALUB, 32'h00008001);
      apply_stimulus(1'b1, enc_r(5'd7, 5'd3, 5'd4, 5'd4, 6'd0), 32'hAA, 32'h1, 1'b0, 1'b0);
      step();
      chk("sll_A", ALUA, 32'h1);
      chk("sll_B", ALUB, 32'h4);

      // beq, bgez, bgtz
      apply_stimulus(1'b1, enc_i(6'd4, 5'd1, 5'd2, 16'h0010), 32'h7, 32'h8, 1'b0, 1'b0);
      step();
      chk("beq_br", 32'(BranchType), 32'd1);
      apply_stimulus(1'b1, enc_i(6'd1, 5'd1, 5'd1, 16'h0020), 32'h7, 32'h8, 1'b0, 1'b0);
      step();
      chk("bgez_br", 32'(BranchType), 32'd3);
      chk("bgez_B", ALUB, 32'd0);
      apply_stimulus(1'b1, enc_i(6'd7, 5'd1, 5'd0, 16'h0030), 32'h7, 32'h8, 1'b0, 1'b0);
      step();
      chk("bgtz_br", 32'(BranchType), 32'd4);
      chk("bgtz_ctrl", 32'(ALUControl), 32'b100010);

      // Capture, stall three cycles with changing inputs, then flush during stall
      apply_stimulus(1'b1, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd34), 32'h1234, 32'h0034, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b1, rand_instr(), $urandom, $urandom, 1'b1, 1'b0);
         step();
         chk("stall_A", ALUA, 32'h1234);
      end
      apply_stimulus(1'b1, enc_i(6'd8, 5'd1, 5'd1, 16'h1), 32'h1, 32'h1, 1'b1, 1'b1);
      step();
      chk("flush_valid", 32'(OutValid), 32'd0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         apply_stimulus(($urandom_range(0, 4) != 0), rand_instr(), $urandom, $urandom,
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
         step();
      end

      // 257 back-to-back illegal instructions saturate the counter
      for (int k = 0; k < 257; k++) begin
         apply_stimulus(1'b1, {6'b111111, 26'($urandom)}, $urandom, $urandom, 1'b0, 1'b0);
         step();
      end
      chk("sat_count", 32'(IllegalCount), 32'd255);
      chk("sat_pulse", 32'(Illegal), 32'd1);

      // Asynchronous reset mid-cycle
      apply_stimulus(1'b1, enc_i(6'd8, 5'd1, 5'd1, 16'h5), 32'h3, 32'h4, 1'b0, 1'b0);
      step();
      #2 Rst_n = 1'b0;
      #1;
      load_bubble();
      e_ill = 1'b0;
      e_cnt = 0;
      check_output();
      #1 Rst_n = 1'b1;
      @(posedge Clk);
      #1;

      // One more issue after reset
      apply_stimulus(1'b1, {6'd28, 5'd1, 5'd2, 5'd0, 5'd0, 6'd2}, 32'h11, 32'h22, 1'b0, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
